// File: rtl/bp_cfg_loader.sv
// Boot-time config master: freeze, stream CCE ucode from a sync ROM, set NPC, set CCE mode, unfreeze.
// Latency: one command per handshake; one cycle ROM latency after each ucode index change.
// Backpressure: holds mem_cmd_o/mem_cmd_v_o stable until ready; caps writes in flight at max_outstanding_p.
//
// Ports:
//   clk_i, reset_i                - clock, synchronous active-high reset
//   mem_cmd_o/_v_o/_ready_i       - uncached write commands {msg_type[3:0], size[2:0], addr, data}
//   mem_resp_i/_v_i/_yumi_o       - write acknowledgements, always consumed on arrival
//   ucode_addr_o, ucode_data_i    - external synchronous microcode ROM
//   done_o, error_o               - sticky completion and protocol-error flags
//
// The processor configuration is flattened into the width parameters below.
module bp_cfg_loader #(
  parameter int paddr_width_p     = 40,
  parameter int cce_instr_width_p = 48,
  parameter int dword_width_p     = 64,
  parameter int ucode_entries_p   = 256,
  parameter int max_outstanding_p = 2,
  parameter logic [paddr_width_p-1:0] cfg_freeze_addr_p     = 'h0_0008,
  parameter logic [paddr_width_p-1:0] cfg_npc_addr_p        = 'h0_0010,
  parameter logic [paddr_width_p-1:0] cfg_cce_mode_addr_p   = 'h0_0018,
  parameter logic [paddr_width_p-1:0] cfg_ucode_base_addr_p = 'h0_8000,
  parameter logic [dword_width_p-1:0] boot_npc_p            = 'h8000_0000,
  localparam int cce_mem_msg_width_lp = 4 + 3 + paddr_width_p + dword_width_p,
  localparam int ucode_addr_width_lp  = (ucode_entries_p > 1) ? $clog2(ucode_entries_p) : 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,
  output logic [ucode_addr_width_lp-1:0]  ucode_addr_o,
  input  logic [cce_instr_width_p-1:0]    ucode_data_i,
  output logic                            done_o,
  output logic                            error_o
);

  localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;
  localparam logic [2:0] e_size_8b       = 3'd3;

  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_width_lp-1:0] max_out_lp = cnt_width_lp'(max_outstanding_p);
  localparam logic [ucode_addr_width_lp-1:0] last_idx_lp =
    ucode_addr_width_lp'((ucode_entries_p > 0) ? ucode_entries_p - 1 : 0);

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FREEZE   = 4'd1;
  localparam logic [3:0] S_UCODE    = 4'd2;
  localparam logic [3:0] S_NPC      = 4'd3;
  localparam logic [3:0] S_MODE     = 4'd4;
  localparam logic [3:0] S_DRAIN    = 4'd5;
  localparam logic [3:0] S_UNFREEZE = 4'd6;
  localparam logic [3:0] S_FENCE    = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]                     r_state;
  logic [cnt_width_lp-1:0]        r_out_cnt;
  logic [ucode_addr_width_lp-1:0] r_idx;
  logic                           r_rom_valid;
  logic                           r_error;

  logic [3:0]                     w_state_nxt;
  logic                           w_write_state;
  logic                           w_cmd_v;
  logic                           w_cmd_hs;
  logic                           w_resp_dec;
  logic                           w_resp_bad;
  logic [paddr_width_p-1:0]       w_addr;
  logic [dword_width_p-1:0]       w_data;
  logic [3:0]                     w_resp_type;
  logic                           w_unused_resp;

  assign w_resp_type   = mem_resp_i[cce_mem_msg_width_lp-1 -: 4];
  assign w_unused_resp = ^mem_resp_i[cce_mem_msg_width_lp-5:0];

  assign w_write_state = (r_state == S_FREEZE) || (r_state == S_UCODE) || (r_state == S_NPC)
                      || (r_state == S_MODE) || (r_state == S_UNFREEZE);

  // Valid depends only on registered state, so it can only stay up until the handshake:
  // responses lower the count but never raise it.
  assign w_cmd_v  = w_write_state && (r_out_cnt < max_out_lp)
                 && ((r_state != S_UCODE) || r_rom_valid);
  assign w_cmd_hs = w_cmd_v && mem_cmd_ready_i;

  assign mem_resp_yumi_o = mem_resp_v_i && !reset_i;
  // A response with nothing in flight is flagged but never underflows the counter.
  assign w_resp_dec = mem_resp_yumi_o && (r_out_cnt != '0);
  assign w_resp_bad = mem_resp_yumi_o && ((w_resp_type != e_cce_mem_uc_wr) || (r_out_cnt == '0));

  always_comb begin
    w_addr = cfg_freeze_addr_p;
    w_data = '0;
    case (r_state)
      S_FREEZE: w_data = dword_width_p'(1);
      S_UCODE: begin
        w_addr = cfg_ucode_base_addr_p + (paddr_width_p'(r_idx) << 3);
        w_data[cce_instr_width_p-1:0] = ucode_data_i;
      end
      S_NPC: begin
        w_addr = cfg_npc_addr_p;
        w_data = boot_npc_p;
      end
      S_MODE: begin
        w_addr = cfg_cce_mode_addr_p;
        w_data = dword_width_p'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET:    w_state_nxt = S_FREEZE;
      S_FREEZE:   if (w_cmd_hs) w_state_nxt = (ucode_entries_p == 0) ? S_NPC : S_UCODE;
      S_UCODE:    if (w_cmd_hs && (r_idx == last_idx_lp)) w_state_nxt = S_NPC;
      S_NPC:      if (w_cmd_hs) w_state_nxt = S_MODE;
      S_MODE:     if (w_cmd_hs) w_state_nxt = S_DRAIN;
      S_DRAIN:    if (r_out_cnt == '0) w_state_nxt = S_UNFREEZE;
      S_UNFREEZE: if (w_cmd_hs) w_state_nxt = S_FENCE;
      S_FENCE:    if (r_out_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_DONE;
      default:    w_state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= S_RESET;
      r_out_cnt   <= '0;
      r_idx       <= '0;
      r_rom_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case ({w_cmd_hs, w_resp_dec})
        2'b10:   r_out_cnt <= r_out_cnt + cnt_width_lp'(1);
        2'b01:   r_out_cnt <= r_out_cnt - cnt_width_lp'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
      // ROM data is only trusted one full cycle after the address settles.
      if ((r_state == S_UCODE) && w_cmd_hs) begin
        r_idx       <= r_idx + ucode_addr_width_lp'(1);
        r_rom_valid <= 1'b0;
      end else begin
        r_rom_valid <= 1'b1;
      end
      if (w_resp_bad) r_error <= 1'b1;
    end
  end

  assign mem_cmd_o    = {e_cce_mem_uc_wr, e_size_8b, w_addr, w_data};
  assign mem_cmd_v_o  = w_cmd_v;
  assign ucode_addr_o = r_idx;
  assign done_o       = (r_state == S_DONE);
  assign error_o      = r_error;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: instance 0 has 4 ucode words, instance 1 has none.
// Expected commands are queued when each sequence starts and popped on every handshake.
// A small ROM model and an auto-responder stand in for the downstream config block.
module tb_bp_cfg_loader;

  localparam int MW = 4 + 3 + 40 + 64;
  localparam logic [3:0] UC_RD = 4'd2;
  localparam logic [3:0] UC_WR = 4'd3;

  typedef struct {
    logic [39:0] addr;
    logic [63:0] data;
  } exp_t;

  logic          clk;
  logic          rst    [2];
  logic [MW-1:0] cmd    [2];
  logic          cmd_v  [2];
  logic          rdy    [2];
  logic [MW-1:0] resp   [2];
  logic          resp_v [2];
  logic          yumi   [2];
  logic [47:0]   rom    [2];
  logic          done   [2];
  logic          err    [2];
  logic [1:0]    ua0;
  logic          ua1;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            pend = 0;
  int            hs = 0;
  bit            bad_type_next = 0;
  bit            stall_prev = 0;
  logic [MW-1:0] stall_cmd;
  int            stall_ua;

  bp_cfg_loader #(.ucode_entries_p(4), .max_outstanding_p(2)) u_dut4 (
    .clk_i(clk), .reset_i(rst[0]),
    .mem_cmd_o(cmd[0]), .mem_cmd_v_o(cmd_v[0]), .mem_cmd_ready_i(rdy[0]),
    .mem_resp_i(resp[0]), .mem_resp_v_i(resp_v[0]), .mem_resp_yumi_o(yumi[0]),
    .ucode_addr_o(ua0), .ucode_data_i(rom[0]),
    .done_o(done[0]), .error_o(err[0])
  );

  bp_cfg_loader #(.ucode_entries_p(0), .max_outstanding_p(2)) u_dut0 (
    .clk_i(clk), .reset_i(rst[1]),
    .mem_cmd_o(cmd[1]), .mem_cmd_v_o(cmd_v[1]), .mem_cmd_ready_i(rdy[1]),
    .mem_resp_i(resp[1]), .mem_resp_v_i(resp_v[1]), .mem_resp_yumi_o(yumi[1]),
    .ucode_addr_o(ua1), .ucode_data_i(rom[1]),
    .done_o(done[1]), .error_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] rom_word(input int i);
    logic [47:0] w;
    w = 48'hA5C3_0000_0000 | (48'(i) << 8) | 48'(i + 1);
    return w;
  endfunction

  // Synchronous ROM: data follows the address by one cycle.
  always @(posedge clk) begin
    rom[0] <= rom_word(int'(ua0));
    rom[1] <= rom_word(int'(ua1));
  end

  function automatic logic [MW-1:0] mk_resp(input logic [3:0] t);
    logic [MW-1:0] r;
    r = '0;
    r[MW-1 -: 4] = t;
    r[MW-5 -: 3] = 3'd3;
    return r;
  endfunction

  function automatic int ua_of(input int d);
    return (d == 0) ? int'(ua0) : int'(ua1);
  endfunction

  task automatic push(input logic [39:0] a, input logic [63:0] v);
    exp_t e;
    e.addr = a;
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input int d);
    push(40'h8, 64'h1);
    if (d == 0)
      for (int i = 0; i < 4; i++) push(40'h8000 + 40'(8 * i), 64'(rom_word(i)));
    push(40'h10, 64'h8000_0000);
    push(40'h18, 64'h1);
    push(40'h8, 64'h0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    pend = 0;
    hs = 0;
    stall_prev = 0;
    bad_type_next = 0;
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1;
    rdy[d] = 1'b0;
    resp_v[d] = 1'b0;
    repeat (3) @(negedge clk);
    rst[d] = 1'b0;
    clear_model();
  endtask

  // One cycle: drive at the falling edge, sample 1 time unit later.
  task automatic cyc(input int d, input bit ready, input bit auto_resp, input bit inject);
    exp_t e;
    logic [MW-1:0] c;
    @(negedge clk);
    rdy[d] = ready;
    resp_v[d] = 1'b0;
    if (inject) begin
      resp_v[d] = 1'b1;
      resp[d] = mk_resp(UC_WR);
    end else if (auto_resp && pend > 0) begin
      resp_v[d] = 1'b1;
      resp[d] = mk_resp(bad_type_next ? UC_RD : UC_WR);
      bad_type_next = 0;
      pend--;
    end
    #1;
    if (resp_v[d]) begin
      n_checks++;
      if (yumi[d] !== 1'b1) begin
        n_errors++;
        $display("FAIL yumi: got %b expected 1", yumi[d]);
      end
    end
    if (stall_prev) begin
      n_checks++;
      if (cmd_v[d] !== 1'b1 || cmd[d] !== stall_cmd || ua_of(d) != stall_ua) begin
        n_errors++;
        $display("FAIL stall_hold: got v=%b cmd=%h ua=%0d expected v=1 cmd=%h ua=%0d",
                 cmd_v[d], cmd[d], ua_of(d), stall_cmd, stall_ua);
      end
    end
    stall_prev = (cmd_v[d] === 1'b1) && !ready;
    stall_cmd  = cmd[d];
    stall_ua   = ua_of(d);
    if (cmd_v[d] === 1'b1 && ready) begin
      hs++;
      pend++;
      c = cmd[d];
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_cmd: got cmd=%h expected no command", c);
      end else begin
        e = exp_q.pop_front();
        if (c[MW-1 -: 4] !== UC_WR || c[MW-5 -: 3] !== 3'd3 || c[103:64] !== e.addr || c[63:0] !== e.data) begin
          n_errors++;
          $display("FAIL cmd%0d: got type=%0d size=%0d addr=%h data=%h expected type=3 size=3 addr=%h data=%h",
                   hs, c[MW-1 -: 4], c[MW-5 -: 3], c[103:64], c[63:0], e.addr, e.data);
        end
      end
    end
  endtask

  task automatic run_to_done(input int d, input bit toggle, input bit exp_err, input int exp_hs);
    int n;
    bit ph;
    n = 0;
    ph = 1'b0;
    while (done[d] !== 1'b1 && n < 2000) begin
      cyc(d, toggle ? ph : 1'b1, 1'b1, 1'b0);
      ph = !ph;
      n++;
    end
    n_checks++;
    if (done[d] !== 1'b1) begin
      n_errors++;
      $display("FAIL done: got %b expected 1 within 2000 cycles", done[d]);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_cmds: got %0d left expected 0", exp_q.size());
    end
    n_checks++;
    if (hs != exp_hs) begin
      n_errors++;
      $display("FAIL handshakes: got %0d expected %0d", hs, exp_hs);
    end
    n_checks++;
    if (err[d] !== exp_err) begin
      n_errors++;
      $display("FAIL error_flag: got %b expected %b", err[d], exp_err);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      resp_v[d] = 1'b1;
      resp[d] = mk_resp(UC_WR);
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cmd_v[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0 || yumi[d] !== 1'b0 || ua_of(d) != 0) begin
        n_errors++;
        $display("FAIL reset%0d: got v=%b done=%b err=%b yumi=%b ua=%0d expected all 0",
                 d, cmd_v[d], done[d], err[d], yumi[d], ua_of(d));
      end
      resp_v[d] = 1'b0;
    end
  endtask

  task automatic test_basic_seq();
    do_reset(0);
    push_seq(0);
    run_to_done(0, 1'b0, 1'b0, 8);
  endtask

  task automatic test_outstanding_limit();
    do_reset(0);
    push_seq(0);
    repeat (20) cyc(0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (hs != 2 || cmd_v[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL withheld: got hs=%0d v=%b expected hs=2 v=0", hs, cmd_v[0]);
    end
    cyc(0, 1'b1, 1'b1, 1'b0);
    repeat (10) cyc(0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (hs != 3 || cmd_v[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL release_one: got hs=%0d v=%b expected hs=3 v=0", hs, cmd_v[0]);
    end
    run_to_done(0, 1'b0, 1'b0, 8);
  endtask

  task automatic test_toggle_ready();
    do_reset(0);
    push_seq(0);
    run_to_done(0, 1'b1, 1'b0, 8);
  endtask

  task automatic test_errors();
    do_reset(0);
    push_seq(0);
    cyc(0, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL unsolicited_err: got %b expected 1", err[0]);
    end
    run_to_done(0, 1'b0, 1'b1, 8);
    do_reset(0);
    push_seq(0);
    bad_type_next = 1'b1;
    run_to_done(0, 1'b0, 1'b1, 8);
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset(0);
    push_seq(0);
    n = 0;
    while (hs < 3 && n < 100) begin
      cyc(0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    cyc(0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if (cmd_v[0] !== 1'b1 || cmd[0][103:64] !== 40'h8010) begin
      n_errors++;
      $display("FAIL word2_pending: got v=%b addr=%h expected v=1 addr=0000008010", cmd_v[0], cmd[0][103:64]);
    end
    rst[0] = 1'b1;
    rdy[0] = 1'b1;
    resp_v[0] = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (cmd_v[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: got v=%b done=%b expected v=0 done=0", cmd_v[0], done[0]);
    end
    rst[0] = 1'b0;
    clear_model();
    push_seq(0);
    run_to_done(0, 1'b0, 1'b0, 8);
  endtask

  task automatic test_zero_ucode();
    @(negedge clk);
    rst[0] = 1'b1;
    do_reset(1);
    push_seq(1);
    run_to_done(1, 1'b0, 1'b0, 4);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      rdy[d] = 1'b0;
      resp_v[d] = 1'b0;
      resp[d] = '0;
    end
    test_reset();
    test_basic_seq();
    test_outstanding_limit();
    test_toggle_ready();
    test_errors();
    test_mid_reset();
    test_zero_ucode();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

endmodule
